// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//   Single-outstanding APB initiator. Takes one command from a valid/ready
//   stream, runs it as an APB SETUP/ACCESS transfer and returns one response
//   on a valid/ready stream. An optional ACCESS-phase watchdog aborts
//   transfers whose slave never raises PREADY.
//
// Ports
//   PCLK, PRESETn        clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (cmd_ready is combinational)
//   cmd_write            1 = write, 0 = read
//   cmd_addr, cmd_wdata  transfer address and write data
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            read data (0 for writes and timeouts)
//   rsp_err              PSLVERR seen or timeout
//   rsp_timeout          transfer aborted by the watchdog
//   PADDR..PWDATA        APB master outputs (all registered)
//   PRDATA, PREADY,      APB slave returns
//   PSLVERR
// -----------------------------------------------------------------------------
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_wait_cnt;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  w_accept;
  logic                  w_complete;
  logic                  w_abort;

  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;
  logic                  r_rsp_timeout;

  // Wait counter sticks at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = (r_state == IDLE) && cmd_valid;
    w_complete  = (r_state == ACCESS) && PREADY;
    w_cnt_inc   = sat_inc(r_wait_cnt);
    // Abort on the PREADY-low cycle that brings the count up to the limit;
    // PREADY in that same cycle takes priority and completes normally.
    w_abort     = TIMEOUT_EN && (r_state == ACCESS) && !PREADY &&
                  (w_cnt_inc == CNT_LIMIT);
    case (r_state)
      IDLE:    if (cmd_valid) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = ACCESS;
      ACCESS:  if (w_complete || w_abort) w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Registered APB and response outputs, updated on state transitions.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_wait_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_paddr    <= cmd_addr;
            r_pwrite   <= cmd_write;
            r_pwdata   <= cmd_wdata;
            r_psel     <= 1'b1;
            r_wait_cnt <= '0;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
        end
        ACCESS: begin
          if (w_complete) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= PSLVERR;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= r_pwrite ? '0 : PRDATA;
          end else if (w_abort) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_rdata   <= '0;
          end else begin
            r_wait_cnt <= w_cnt_inc;
          end
        end
        RESP: begin
          if (rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready   = (r_state == IDLE);
  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
//   Directed bench for apb_master_bridge (TIMEOUT_CYCLES = 8). The stimulus
//   process pushes the expected response of every command into a queue; a
//   monitor pops and compares on each response handshake. A small APB slave
//   model inserts a configurable number of wait states and drives junk on
//   PRDATA/PSLVERR whenever PREADY is low.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          PCLK;
  logic          PRESETn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } rsp_t;

  rsp_t        exp_q[$];
  int          n_chk    = 0;
  int          n_pass   = 0;
  int          sl_waits = 0;
  logic [31:0] sl_rdata = '0;
  logic        sl_err   = 1'b0;
  bit          seen_m;

  apb_master_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // APB slave model: PREADY rises in the (sl_waits+1)-th ACCESS cycle.
  initial begin
    int acc;
    acc     = 0;
    PREADY  = 1'b0;
    PRDATA  = 32'hBADBAD00;
    PSLVERR = 1'b1;
    forever begin
      @(negedge PCLK);
      if (PSEL && PENABLE) acc++;
      else acc = 0;
      if (acc > sl_waits) begin
        PREADY  = 1'b1;
        PRDATA  = sl_rdata;
        PSLVERR = sl_err;
      end else begin
        PREADY  = 1'b0;
        PRDATA  = 32'hBADBAD00;
        PSLVERR = 1'b1;
      end
    end
  end

  // Response monitor / scoreboard.
  initial begin
    rsp_t e;
    forever begin
      @(negedge PCLK);
      if (PRESETn && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          check("rsp_err", 64'(rsp_err), 64'(e.err));
          check("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] rd, input logic err, input logic to);
    rsp_t e;
    e.rdata = rd;
    e.err   = err;
    e.to    = to;
    exp_q.push_back(e);
  endtask

  task automatic accept(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok;
    ok        = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge PCLK);
      if (cmd_ready) ok = 1'b1;
    end
    check("cmd_accept", 64'(ok), 64'd1);
    @(posedge PCLK);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int pen_exp, input logic [31:0] rd_exp,
                      input logic err_exp, input logic to_exp, input int lat_exp);
    int n;
    int pen;
    bit seen;
    bit stable;
    push_exp(rd_exp, err_exp, to_exp);
    accept(w, a, d);
    @(negedge PCLK);
    check("setup_psel_penable", 64'({PSEL, PENABLE}), 64'(2'b10));
    check("setup_paddr", 64'(PADDR), 64'(a));
    check("setup_pwrite_pwdata", 64'({PWRITE, PWDATA}), 64'({w, d}));
    n = 1; pen = 0; seen = 1'b0; stable = 1'b1;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge PCLK);
      n++;
      if (rsp_valid) seen = 1'b1;
      else if (PENABLE) begin
        pen++;
        if (PADDR !== a || PSEL !== 1'b1 || PWRITE !== w) stable = 1'b0;
      end
    end
    check("rsp_seen", 64'(seen), 64'd1);
    check("access_cycles", 64'(pen), 64'(pen_exp));
    check("access_stable", 64'(stable), 64'd1);
    check("psel_drop", 64'({PSEL, PENABLE}), 64'd0);
    if (lat_exp > 0) check("latency", 64'(n), 64'(lat_exp));
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge PCLK);
    check("reset_ctrl", 64'({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout}), 64'd0);
    check("reset_paddr_pwdata", 64'({PADDR, PWDATA}), 64'd0);
    check("reset_rdata", 64'(rsp_rdata), 64'd0);
    check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge PCLK);
    #1;
    PRESETn = 1'b1;

    // zero-wait write
    sl_waits = 0; sl_err = 1'b0; sl_rdata = 32'h77777777;
    xfer(1'b1, 12'h010, 32'hDEADBEEF, 1, 32'h0, 1'b0, 1'b0, 3);

    // bus holds last values while idle
    repeat (3) @(negedge PCLK);
    check("idle_hold", 64'({PADDR, PWRITE, PWDATA}), 64'({12'h010, 1'b1, 32'hDEADBEEF}));
    check("idle_ctrl", 64'({PSEL, PENABLE, rsp_valid, cmd_ready}), 64'(4'b0001));
    @(posedge PCLK);
    #1;

    // read with 3 wait states
    sl_waits = 3; sl_rdata = 32'h12345678;
    xfer(1'b0, 12'h0FC, 32'h0, 4, 32'h12345678, 1'b0, 1'b0, 0);

    // slave error on write, then a normal read
    sl_waits = 0; sl_err = 1'b1;
    xfer(1'b1, 12'h020, 32'h0BADCAFE, 1, 32'h0, 1'b1, 1'b0, 0);
    sl_err = 1'b0; sl_waits = 1; sl_rdata = 32'hA5A5A5A5;
    xfer(1'b0, 12'h024, 32'h0, 2, 32'hA5A5A5A5, 1'b0, 1'b0, 0);

    // timeout: PREADY never rises
    sl_waits = 1000;
    xfer(1'b0, 12'h030, 32'h0, 8, 32'h0, 1'b1, 1'b1, 0);

    // PREADY arrives in the same cycle the limit is reached
    sl_waits = 7; sl_rdata = 32'h0F0F0F0F;
    xfer(1'b0, 12'h034, 32'h0, 8, 32'h0F0F0F0F, 1'b0, 1'b0, 0);

    // response backpressure with a second command pending
    sl_waits = 0; sl_rdata = 32'h11112222; rsp_ready = 1'b0;
    push_exp(32'h11112222, 1'b0, 1'b0);
    accept(1'b0, 12'h040, 32'h0);
    seen_m = 1'b0;
    for (int i = 0; i < 20 && !seen_m; i++) begin
      @(negedge PCLK);
      if (rsp_valid) seen_m = 1'b1;
    end
    check("bp_rsp_seen", 64'(seen_m), 64'd1);
    push_exp(32'h0, 1'b0, 1'b0);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h044; cmd_wdata = 32'h55AA55AA;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", 64'({rsp_valid, rsp_err, rsp_timeout, cmd_ready, PSEL, rsp_rdata}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h11112222}));
      @(negedge PCLK);
    end
    @(posedge PCLK);
    #1;
    rsp_ready = 1'b1;
    @(negedge PCLK);
    @(negedge PCLK);
    check("bp_after_handshake", 64'({cmd_ready, PSEL, rsp_valid}), 64'(3'b100));
    @(posedge PCLK);
    #1;
    cmd_valid = 1'b0;
    @(negedge PCLK);
    check("bp_second_setup", 64'({PSEL, PENABLE, PWRITE, PADDR}), 64'({1'b1, 1'b0, 1'b1, 12'h044}));
    seen_m = 1'b0;
    for (int i = 0; i < 20 && !seen_m; i++) begin
      @(negedge PCLK);
      if (rsp_valid) seen_m = 1'b1;
    end
    check("bp_second_rsp", 64'(seen_m), 64'd1);
    @(posedge PCLK);
    #1;

    // asynchronous reset in the middle of ACCESS
    sl_waits = 1000;
    accept(1'b0, 12'h050, 32'h0);
    repeat (3) @(negedge PCLK);
    check("rst_pre_access", 64'({PSEL, PENABLE}), 64'(2'b11));
    #2;
    PRESETn = 1'b0;
    #1;
    check("rst_async_drop", 64'({PSEL, PENABLE, rsp_valid}), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    sl_waits = 2; sl_rdata = 32'hCAFEF00D;
    xfer(1'b0, 12'h0A4, 32'h0, 3, 32'hCAFEF00D, 1'b0, 1'b0, 0);

    repeat (2) @(negedge PCLK);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
